// File: rtl/btn_event_fifo.sv
// Key-press event queue: edge-detects the scanner's 20-bit level vector and queues key indices in a FWFT FIFO.
// Optional release events are enabled with the BTN_EVENT_RELEASE_EN macro.
module btn_event_fifo #(
  parameter int DEPTH      = 8,
  parameter int DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [19:0]           keys,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [5:0]            key_code,
  output logic                  valid,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow
);

  localparam logic [DEPTH_BITS:0]   FULL_COUNT = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0]   COUNT_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [DEPTH_BITS-1:0] PTR_ONE    = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

  logic [19:0]           keys_prev;
  logic [19:0]           pending;
  logic [19:0]           new_press;
  logic [19:0]           grant;
  logic                  issue;
  logic [5:0]            issue_code;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [5:0]            mem [DEPTH];

  assign new_press = keys & ~keys_prev;

`ifdef BTN_EVENT_RELEASE_EN
  logic [19:0] pending_rel;
  logic [19:0] new_release;
  logic [19:0] grant_rel;

  assign new_release = ~keys & keys_prev;

  // Presses always win; releases are only served once no press is waiting.
  always_comb begin
    grant      = '0;
    grant_rel  = '0;
    issue_code = '0;
    for (int i = 19; i >= 0; i--) begin
      if (pending_rel[i]) begin
        grant_rel  = 20'd1 << i;
        issue_code = {1'b1, 5'(i)};
      end
    end
    if (pending != '0) begin
      grant_rel = '0;
      for (int i = 19; i >= 0; i--) begin
        if (pending[i]) begin
          grant      = 20'd1 << i;
          issue_code = {1'b0, 5'(i)};
        end
      end
    end
    issue = (pending != '0) || (pending_rel != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_rel <= '0;
    end else begin
      pending_rel <= (pending_rel & ~grant_rel) | new_release;
    end
  end
`else
  // Descending scan so the lowest set bit is the one left standing.
  always_comb begin
    grant      = '0;
    issue_code = '0;
    for (int i = 19; i >= 0; i--) begin
      if (pending[i]) begin
        grant      = 20'd1 << i;
        issue_code = {1'b0, 5'(i)};
      end
    end
    issue = (pending != '0);
  end
`endif

  // A full FIFO still accepts the event if the same cycle pops the head.
  assign pop   = rd_en && (count != '0);
  assign push  = issue && ((count != FULL_COUNT) || rd_en);
  assign drop  = issue && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_prev <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      keys_prev <= keys;
      pending   <= (pending & ~grant) | new_press;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= issue_code;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + COUNT_ONE;
      end else if (pop && !push) begin
        count <= count - COUNT_ONE;
      end
    end
  end

  assign key_code = mem[rd_ptr];
  assign valid    = (count != '0);

endmodule

// File: tb/tb_btn_event_fifo.sv
// Self-checking bench for btn_event_fifo: directed scenarios plus random key/read traffic,
// all compared against a queue-based event model.
module tb_btn_event_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] keys;
  logic        rd_en;
  logic        clr_ovf;
  logic [5:0]  key_code;
  logic        valid;
  logic [3:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [19:0] m_prev;
  logic [19:0] m_press;
  logic [19:0] m_rel;
  logic        m_ovf;
  logic [5:0]  m_fifo [$];

  btn_event_fifo #(.DEPTH(DEPTH), .DEPTH_BITS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .keys     (keys),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .key_code (key_code),
    .valid    (valid),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // One clock of the event model: pick one waiting event, apply pop/push, then record new edges.
  task automatic modelStep();
    logic       have_evt;
    logic [5:0] evt;
    int         held;
    have_evt = 1'b0;
    evt      = '0;
    for (int i = 0; i < 20; i++) begin
      if (!have_evt && m_press[i]) begin
        have_evt   = 1'b1;
        evt        = {1'b0, 5'(i)};
        m_press[i] = 1'b0;
      end
    end
`ifdef BTN_EVENT_RELEASE_EN
    for (int i = 0; i < 20; i++) begin
      if (!have_evt && m_rel[i]) begin
        have_evt = 1'b1;
        evt      = {1'b1, 5'(i)};
        m_rel[i] = 1'b0;
      end
    end
    m_rel = m_rel | (~keys & m_prev);
`endif
    held = m_fifo.size();
    if (rd_en && held > 0) void'(m_fifo.pop_front());
    if (have_evt) begin
      if (held < DEPTH || rd_en) m_fifo.push_back(evt);
      else m_ovf = 1'b1;
    end
    if (!(have_evt && held == DEPTH && !rd_en) && clr_ovf) m_ovf = 1'b0;
    m_press = m_press | (keys & ~m_prev);
    m_prev  = keys;
  endtask

  task automatic applyStimulus(input logic [19:0] k, input logic r, input logic c);
    @(negedge clk);
    keys    = k;
    rd_en   = r;
    clr_ovf = c;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("valid", 32'(valid), 32'(m_fifo.size() != 0));
    checkOutput("count", 32'(count), 32'(m_fifo.size()));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    if (m_fifo.size() != 0) checkOutput("key_code", 32'(key_code), 32'(m_fifo[0]));
  endtask

  initial begin
    logic [19:0] cur;
    rst_n   = 1'b0;
    keys    = '0;
    rd_en   = 1'b0;
    clr_ovf = 1'b0;
    m_prev  = '0;
    m_press = '0;
    m_rel   = '0;
    m_ovf   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_key_code", 32'(key_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(20'h0, 1'b1, 1'b0);
    checkOutput("empty_read_count", 32'(count), 32'd0);

    // Single press: not visible after the capture edge, visible after the issue edge.
    applyStimulus(20'h00010, 1'b0, 1'b0);
    checkOutput("press_latency_valid", 32'(valid), 32'd0);
    applyStimulus(20'h00010, 1'b0, 1'b0);
    checkOutput("press_code", 32'(key_code), 32'd4);
    checkOutput("press_count", 32'(count), 32'd1);
    applyStimulus(20'h00010, 1'b1, 1'b0);
    checkOutput("press_pop_valid", 32'(valid), 32'd0);
    applyStimulus(20'h0, 1'b0, 1'b0);
    applyStimulus(20'h0, 1'b0, 1'b0);

    // Three simultaneous presses drain in ascending order.
    repeat (5) applyStimulus(20'h80005, 1'b0, 1'b0);
    checkOutput("multi_count", 32'(count), 32'd3);
    checkOutput("multi_first", 32'(key_code), 32'd0);
    applyStimulus(20'h80005, 1'b1, 1'b0);
    checkOutput("multi_second", 32'(key_code), 32'd2);
    applyStimulus(20'h80005, 1'b1, 1'b0);
    checkOutput("multi_third", 32'(key_code), 32'd19);
    applyStimulus(20'h80005, 1'b1, 1'b0);
    checkOutput("multi_empty", 32'(count), 32'd0);
    applyStimulus(20'h0, 1'b1, 1'b0);
    repeat (6) applyStimulus(20'h0, 1'b1, 1'b0);
    applyStimulus(20'h0, 1'b0, 1'b1);

    // Nine presses into an eight-deep FIFO: key 8 is dropped.
    repeat (11) applyStimulus(20'h001FF, 1'b0, 1'b0);
    checkOutput("full_count", 32'(count), 32'd8);
    checkOutput("full_overflow", 32'(overflow), 32'd1);
    checkOutput("full_head", 32'(key_code), 32'd0);
    applyStimulus(20'h001FF, 1'b0, 1'b1);
    checkOutput("clr_overflow", 32'(overflow), 32'd0);

    // New press while full, with a pop in the issue cycle.
    applyStimulus(20'h011FF, 1'b0, 1'b0);
    applyStimulus(20'h011FF, 1'b1, 1'b0);
    checkOutput("swap_count", 32'(count), 32'd8);
    checkOutput("swap_overflow", 32'(overflow), 32'd0);
    checkOutput("swap_head", 32'(key_code), 32'd1);
    repeat (7) applyStimulus(20'h011FF, 1'b1, 1'b0);
    checkOutput("swap_tail", 32'(key_code), 32'd12);
    checkOutput("swap_tail_count", 32'(count), 32'd1);
    repeat (14) applyStimulus(20'h0, 1'b1, 1'b0);
    applyStimulus(20'h0, 1'b0, 1'b1);
    checkOutput("drained", 32'(count), 32'd0);

    // Release of key 3.
    repeat (3) applyStimulus(20'h00008, 1'b0, 1'b0);
    checkOutput("k3_code", 32'(key_code), 32'd3);
    applyStimulus(20'h00008, 1'b1, 1'b0);
    repeat (3) applyStimulus(20'h0, 1'b0, 1'b0);
`ifdef BTN_EVENT_RELEASE_EN
    checkOutput("release_count", 32'(count), 32'd1);
    checkOutput("release_code", 32'(key_code), 32'h23);
`else
    checkOutput("release_count", 32'(count), 32'd0);
`endif
    repeat (2) applyStimulus(20'h0, 1'b1, 1'b0);

    // Random traffic.
    cur = '0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) cur = cur ^ (20'd1 << $urandom_range(0, 19));
      if ($urandom_range(0, 9) == 0) cur = cur ^ 20'($urandom);
      applyStimulus(cur, ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
